// File: rtl/mem_bus_controller.sv
// Purpose: arbitrates fetch and data ports onto the unified memory's shared address/data/write_mode bus.
// Latency: ready pulses 3 edges after the request is sampled for reads, 2 for writes, 1 for rejected requests.
// Backpressure: requesters hold req until ready; one access is in flight at a time, and the other port waits in IDLE.
module mem_bus_controller #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 16,
    parameter bit PROTECT_IMEM = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] address_bus,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              write_mode
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              gnt_d_q;
    logic              last_d_q;
    logic              rej_q;

    logic              any_req;
    logic              pick_d;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic              sel_rej;

    // Data port wins contention unless it also won last time, so the ports strictly alternate.
    always_comb begin
        any_req  = if_req | d_req;
        pick_d   = d_req & (~if_req | ~last_d_q);
        sel_addr = pick_d ? d_addr : if_addr;
        sel_we   = pick_d & d_we;
        sel_rej  = sel_addr[0] |
                   (PROTECT_IMEM & sel_we & (sel_addr[ADDR_W-1:ADDR_W-2] == 2'b00));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (sel_rej)     state_d = DONE;
                    else if (sel_we) state_d = WR;
                    else             state_d = RD_ADDR;
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: state_d = DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_d_q  <= 1'b0;
            last_d_q <= 1'b0;
            rej_q    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if (state_q == IDLE && any_req) begin
                addr_q   <= sel_addr;
                wdata_q  <= d_wdata;
                gnt_d_q  <= pick_d;
                last_d_q <= pick_d;
                rej_q    <= sel_rej;
            end
            // Memory output has settled by the end of RD_DATA.
            if (state_q == RD_DATA) begin
                if (gnt_d_q) d_rdata  <= data_bus;
                else         if_rdata <= data_bus;
            end
        end
    end

    assign address_bus = addr_q;
    assign write_mode  = (state_q == WR);
    // Output enable is write_mode itself, so the memory and the controller never drive together.
    assign data_bus    = write_mode ? wdata_q : {DATA_W{1'bz}};
    assign if_ready    = (state_q == DONE) & ~gnt_d_q;
    assign d_ready     = (state_q == DONE) & gnt_d_q;
    assign err         = (state_q == DONE) & rej_q;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Bench for mem_bus_controller: behavioural memory on the bus plus a transaction-level reference model.
module tb_mem_bus_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [11:0] if_addr = '0;
    logic        if_ready;
    logic [15:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [11:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_ready;
    logic [15:0] d_rdata;
    logic        err;
    logic [11:0] address_bus;
    wire  [15:0] data_bus;
    logic        write_mode;

    always #5 clk = ~clk;

    mem_bus_controller #(.ADDR_W(12), .DATA_W(16), .PROTECT_IMEM(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .err(err),
        .address_bus(address_bus), .data_bus(data_bus), .write_mode(write_mode)
    );

    // Synchronous-read memory: samples the address each edge, drives data_bus whenever not written.
    logic [15:0] mem [0:2047];
    logic [15:0] mem_q = '0;
    always @(posedge clk) begin
        mem_q <= mem[address_bus[11:1]];
        if (write_mode) mem[address_bus[11:1]] = data_bus;
    end
    assign data_bus = write_mode ? 16'bz : mem_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    logic [15:0] ref_mem [0:2047];
    bit          model_last_d = 1'b0;
    logic [15:0] exp_if_rdata = '0;
    logic [15:0] exp_d_rdata = '0;

    logic [15:0] cur_wdata = '0;
    int          wm_cycles = 0;

    always @(negedge clk) begin
        if (write_mode) begin
            wm_cycles++;
            check("wr_bus", data_bus, cur_wdata);
        end else begin
            check("bus_release", data_bus, mem_q);
        end
    end

    function automatic bit d_rejected(input bit we, input logic [11:0] a);
        return a[0] || (we && a[11:10] == 2'b00);
    endfunction

    task automatic model_fetch(input logic [11:0] a);
        if (!a[0]) exp_if_rdata = ref_mem[a[11:1]];
        model_last_d = 1'b0;
    endtask

    task automatic model_data(input bit we, input logic [11:0] a, input logic [15:0] wd);
        if (!d_rejected(we, a)) begin
            if (we) ref_mem[a[11:1]] = wd;
            else    exp_d_rdata = ref_mem[a[11:1]];
        end
        model_last_d = 1'b1;
    endtask

    task automatic run_round(input bit use_f, input logic [11:0] fa,
                             input bit use_d, input bit dwe, input logic [11:0] da,
                             input logic [15:0] dwd);
        int  c0, wm0, lat_f, lat_d, exp_f, exp_d;
        bit  f_rej, d_rej, f_first, f_done, d_done;
        f_rej  = fa[0];
        d_rej  = d_rejected(dwe, da);
        lat_f  = f_rej ? 1 : 3;
        lat_d  = d_rej ? 1 : (dwe ? 2 : 3);
        f_first = use_f && !(use_d && !model_last_d);
        exp_f = 0;
        exp_d = 0;
        if (use_f && use_d) begin
            if (f_first) begin
                model_fetch(fa); model_data(dwe, da, dwd);
                exp_f = lat_f; exp_d = lat_f + 1 + lat_d;
            end else begin
                model_data(dwe, da, dwd); model_fetch(fa);
                exp_d = lat_d; exp_f = lat_d + 1 + lat_f;
            end
        end else if (use_f) begin
            model_fetch(fa); exp_f = lat_f;
        end else if (use_d) begin
            model_data(dwe, da, dwd); exp_d = lat_d;
        end
        cur_wdata = dwd;
        wm0 = wm_cycles;
        c0 = cyc;
        if_addr = fa; if_req = use_f;
        d_we = dwe; d_addr = da; d_wdata = dwd; d_req = use_d;
        f_done = !use_f;
        d_done = !use_d;
        for (int k = 0; k < 16 && !(f_done && d_done); k++) begin
            @(posedge clk); #1;
            if (if_ready) begin
                if (f_done) check("if_ready_spurious", 1, 0);
                else begin
                    check("if_latency", cyc - c0, exp_f);
                    check("if_err", err, f_rej);
                    if (!f_rej) check("if_rdata", if_rdata, exp_if_rdata);
                    f_done = 1'b1;
                    if_req = 1'b0;
                end
            end
            if (d_ready) begin
                if (d_done) check("d_ready_spurious", 1, 0);
                else begin
                    check("d_latency", cyc - c0, exp_d);
                    check("d_err", err, d_rej);
                    if (!d_rej && !dwe) check("d_rdata", d_rdata, exp_d_rdata);
                    d_done = 1'b1;
                    d_req = 1'b0;
                end
            end
        end
        if (!f_done) check("if_timeout", 0, 1);
        if (!d_done) check("d_timeout", 0, 1);
        if_req = 1'b0;
        d_req = 1'b0;
        check("write_mode_cycles", wm_cycles - wm0, (use_d && dwe && !d_rej) ? 1 : 0);
        check("if_rdata_hold", if_rdata, exp_if_rdata);
        check("d_rdata_hold", d_rdata, exp_d_rdata);
        @(posedge clk); #1;
    endtask

    // Both ports held high through their ready pulses: grants must alternate.
    task automatic hold_both(input logic [11:0] fa, input logic [11:0] da);
        int c0, seen;
        bit exp_is_d;
        c0 = cyc;
        seen = 0;
        if_addr = fa; d_addr = da; d_we = 1'b0; if_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 40 && seen < 4; k++) begin
            @(posedge clk); #1;
            if (if_ready || d_ready) begin
                exp_is_d = !model_last_d;
                check("alt_port", d_ready, exp_is_d);
                check("alt_latency", cyc - c0, 3 + 4 * seen);
                if (exp_is_d) begin
                    model_data(1'b0, da, '0);
                    check("alt_d_rdata", d_rdata, exp_d_rdata);
                end else begin
                    model_fetch(fa);
                    check("alt_if_rdata", if_rdata, exp_if_rdata);
                end
                seen++;
                if (seen == 4) begin
                    if_req = 1'b0;
                    d_req = 1'b0;
                end
            end
        end
        if (seen != 4) check("alt_timeout", seen, 4);
        if_req = 1'b0;
        d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic reset_during_write(input logic [11:0] a, input logic [15:0] wd);
        cur_wdata = wd;
        d_we = 1'b1; d_addr = a; d_wdata = wd; d_req = 1'b1;
        @(posedge clk); #1;
        check("rst_wr_entered", write_mode, 1);
        #2 rst_n = 1'b0;
        d_req = 1'b0;
        #1;
        check("rst_write_mode", write_mode, 0);
        check("rst_data_bus", data_bus, mem_q);
        check("rst_address_bus", address_bus, 0);
        check("rst_d_ready", d_ready, 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("rst_no_ready", {if_ready, d_ready, err}, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        model_last_d = 1'b0;
        exp_if_rdata = '0;
        exp_d_rdata = '0;
        @(posedge clk); #1;
        // Aborted write must not have landed; a fresh read also proves the FSM restarted in IDLE.
        run_round(0, '0, 1, 0, a, '0);
    endtask

    initial begin
        logic [11:0] fa, da;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 16'($urandom);
        end
        mem[12'hFFC >> 1] = 16'hABCD;
        for (int i = 0; i < 2048; i++) ref_mem[i] = mem[i];

        repeat (3) @(posedge clk);
        #1;
        check("reset_address_bus", address_bus, 0);
        check("reset_if_rdata", if_rdata, 0);
        check("reset_d_rdata", d_rdata, 0);
        check("reset_write_mode", write_mode, 0);
        check("reset_ready_err", {if_ready, d_ready, err}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_round(1, 12'hFFC, 0, 0, '0, '0);
        run_round(0, '0, 1, 1, 12'h402, 16'h1234);
        run_round(0, '0, 1, 0, 12'h402, '0);
        run_round(1, 12'h100, 0, 0, '0, '0);
        hold_both(12'h000, 12'h800);
        run_round(0, '0, 1, 1, 12'h010, 16'h5A5A);
        run_round(0, '0, 1, 0, 12'h010, '0);
        run_round(0, '0, 1, 0, 12'h403, '0);
        run_round(1, 12'h007, 0, 0, '0, '0);
        reset_during_write(12'h806, 16'hC0DE);

        for (int r = 0; r < 150; r++) begin
            int mode;
            mode = $urandom_range(0, 2);
            fa = 12'($urandom) & 12'hFFE;
            da = 12'($urandom) & 12'hFFE;
            if ($urandom_range(0, 7) == 0) fa[0] = 1'b1;
            if ($urandom_range(0, 7) == 0) da[0] = 1'b1;
            if ($urandom_range(0, 5) == 0) da[11:10] = 2'b00;
            run_round(mode != 1, fa, mode != 0, 1'($urandom), da, 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_controller.md
Name: mem_bus_controller

Overview:
- Bus master that sits directly upstream of the 4KB unified memory.
- Accepts requests from the CPU instruction-fetch port and data port, arbitrates between them, and sequences the memory's shared address bus, bidirectional data bus and write_mode line.
- Returns read data and a one-cycle ready pulse to the granted port.
- Only block allowed to drive the memory bus.

Parameters:
- ADDR_W, 12, byte address width on all ports.
- DATA_W, 16, word width.
- PROTECT_IMEM, 1, when 1, writes to the instruction bank (addr[11:10]==2'b00) are rejected with err.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch read request; held high until if_ready.
- if_addr  input  ADDR_W  fetch byte address; held stable while if_req.
- if_ready  output  1  one-cycle completion pulse for fetch.
- if_rdata  output  DATA_W  fetch read data, valid while if_ready.
- d_req  input  1  data request; held high until d_ready.
- d_we  input  1  1=write, 0=read; stable while d_req.
- d_addr  input  ADDR_W  data byte address; stable while d_req.
- d_wdata  input  DATA_W  write data; stable while d_req.
- d_ready  output  1  one-cycle completion pulse for data port.
- d_rdata  output  DATA_W  data read result, valid while d_ready.
- err  output  1  one-cycle pulse alongside ready when a request was rejected.
- address_bus  output  ADDR_W  memory address.
- data_bus  inout  DATA_W  memory data; driven only in WR state, else high-Z.
- write_mode  output  1  memory write strobe, high only in WR state.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - address_bus, if_rdata and d_rdata are 0.
  - write_mode, if_ready, d_ready and err are 0.
  - data_bus is released to high-Z immediately.
  - Any in-flight access is abandoned with no ready pulse; the requester re-issues after reset.
- States: IDLE, RD_ADDR, RD_DATA, WR, DONE.
- IDLE:
  - Requests are sampled on each posedge.
  - If neither request is pending, stay in IDLE; address_bus holds its last value and write_mode is 0.
  - Arbitration: if only one port requests, grant it.
  - If both request, grant the data port unless the previous grant was also data, in which case grant fetch. This strictly alternates under contention.
  - last_grant register: 1 bit, reset to fetch.
  - On grant, latch the address, we and wdata into internal registers and drive address_bus from the latched address.
- Rejection: misaligned address (addr[0]=1), or a write to bank 00 when PROTECT_IMEM=1.
  - Go straight to DONE with err=1.
  - No bus cycle occurs and rdata is unchanged.
- Read sequence:
  - IDLE→RD_ADDR: address_bus valid, write_mode=0; memory samples at the next edge.
  - RD_ADDR→RD_DATA: memory output settles on data_bus.
  - RD_DATA→DONE: capture data_bus into the granted port's rdata register.
- Write sequence:
  - IDLE→WR: write_mode=1 and data_bus driven with the latched wdata in the same cycle; memory writes at the next edge.
  - WR→DONE.
- DONE:
  - The granted port's ready is high for exactly this cycle, plus err if rejected.
  - Requests are not sampled in DONE.
  - Next state is IDLE.
- Latency, counted in edges from the req-sampling edge to the ready cycle:
  - Read: ready is high in the cycle after the 3rd edge.
  - Write: ready is high in the cycle after the 2nd edge.
  - Rejected: ready is high in the cycle after the 1st edge.
- Requester handshake:
  - Must deassert req in the cycle after ready.
  - A req still high in the following IDLE cycle is treated as a new request.
- rdata registers hold their value until the next completed read on the same port.
- Bus contention rule: data_bus output enable equals write_mode, so the controller and memory never drive the bus simultaneously.
- Bank bits addr[11:10] and word index addr[9:1] pass through unmodified.

Test Plan:
- Reset, then a fetch read of 0xFFC (memory preset 0xABCD) -> if_ready high 3 edges after the request, if_rdata=0xABCD, err=0.
- Data write of 0x1234 to 0x402, then a data read of 0x402 -> write ready after 2 edges with write_mode high for exactly 1 cycle; read returns d_rdata=0x1234.
- if_req and d_req both held continuously (reads of 0x000 and 0x800) -> grants alternate D,F,D,F; neither port starves.
- d_req write to 0x010 with PROTECT_IMEM=1 -> d_ready and err pulse 1 edge later; write_mode never asserts; memory at 0x010 unchanged. Misaligned read of 0x403 -> err likewise.
- rst_n dropped in WR cycle -> write_mode and data_bus release immediately; no ready pulse; state is IDLE when rst_n rises.
- Check on every cycle: data_bus is high-Z from the controller whenever write_mode=0.
